// File: rtl/mbssoc_irq_collector_pkg.sv
// ---------------------------------------------------------------------------
// mbssoc_irq_collector_pkg
//   Shared constants for the interrupt collector: number of sources, the
//   fixed source index assignment, and the register-port address map.
// ---------------------------------------------------------------------------
package mbssoc_irq_collector_pkg;

  localparam int INT_SEL_WIDTH = 8;

  // Source indices. Syscall slots sit at the bottom so the default soft
  // mask (8'h03) covers exactly them.
  localparam int INT_SYSCALL0  = 0;
  localparam int INT_SYSCALL1  = 1;
  localparam int INT_KEYBOARD  = 2;
  localparam int INT_MOUSE     = 3;
  localparam int INT_UART      = 4;
  localparam int INT_STORAGE   = 5;
  localparam int INT_ETHERNET  = 6;

  typedef enum logic [1:0] {
    IRQ_REG_MASK    = 2'd0,  // RW
    IRQ_REG_PENDING = 2'd1,  // RO, raw pending (pre-mask)
    IRQ_REG_MISSED  = 2'd2,  // RW1C
    IRQ_REG_SWSET   = 2'd3   // WO, reads 0
  } irq_reg_e;

endpackage

// File: rtl/mbssoc_irq_sync.sv
// ---------------------------------------------------------------------------
// mbssoc_irq_sync
//   One-bit synchroniser followed by a rising-edge detector.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous, active-high reset
//   async_in  in  raw line, asynchronous to clk
//   sync_out  out synchronised level (last synchroniser stage)
//   rise      out 1 for one cycle when sync_out goes 0->1 (combinational)
// ---------------------------------------------------------------------------
module mbssoc_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   sync_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      sync_d <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
      sync_d <= stages[SYNC_STAGES-1];
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_d;

endmodule

// File: rtl/mbssoc_irq_collector.sv
// ---------------------------------------------------------------------------
// mbssoc_irq_collector
//   Interrupt front-end feeding the APIC. Synchronises device lines, latches
//   pending requests (edge or level per source), masks them onto int_vec,
//   clears on int_ack and returns a one-cycle dev_ack pulse per ack rise.
//   Software can raise syscall slots (SWSET) and inspect per-source sticky
//   "missed" flags through a 4-word register port.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   irq_in     [W] raw device requests (async)
//   int_ack    [W] APIC acknowledge, level
//   int_vec    [W] pending & ~mask, to APIC
//   dev_ack    [W] one-cycle pulse after each int_ack rising edge
//   reg_wr/rd  register strobes; reg_addr selects MASK/PENDING/MISSED/SWSET
//   reg_wdata  [W] write data; reg_rdata [W] read data, valid cycle after rd
// ---------------------------------------------------------------------------
module mbssoc_irq_collector
  import mbssoc_irq_collector_pkg::*;
#(
  parameter int           W           = INT_SEL_WIDTH,
  parameter logic [W-1:0] EDGE_MASK   = '1,
  parameter logic [W-1:0] SOFT_MASK   = W'(8'h03),
  parameter int           SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] irq_in,
  input  logic [W-1:0] int_ack,
  output logic [W-1:0] int_vec,
  output logic [W-1:0] dev_ack,
  input  logic         reg_wr,
  input  logic         reg_rd,
  input  logic [1:0]   reg_addr,
  input  logic [W-1:0] reg_wdata,
  output logic [W-1:0] reg_rdata
);

  logic [W-1:0] sync_s;
  logic [W-1:0] sync_rise;

  for (genvar i = 0; i < W; i++) begin : g_sync
    mbssoc_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq_in[i]),
      .sync_out (sync_s[i]),
      .rise     (sync_rise[i])
    );
  end

  logic [W-1:0] pending;
  logic [W-1:0] missed;
  logic [W-1:0] mask;
  logic [W-1:0] int_ack_d;

  logic [W-1:0] sw_set;
  logic [W-1:0] set_ev;
  logic [W-1:0] miss_ev;
  logic [W-1:0] missed_w1c;

  // Register-port side effects, decoded once.
  assign sw_set     = (reg_wr && reg_addr == IRQ_REG_SWSET)  ? (reg_wdata & SOFT_MASK) : '0;
  assign missed_w1c = (reg_wr && reg_addr == IRQ_REG_MISSED) ? reg_wdata : '0;

  assign set_ev  = (EDGE_MASK & sync_rise) | (~EDGE_MASK & sync_s) | sw_set;
  // A held level line re-asserting itself is not a lost request, so only
  // edge and software events can be counted as misses. An ack in the same
  // cycle means the earlier request is being serviced, not overwritten.
  assign miss_ev = ((EDGE_MASK & sync_rise) | sw_set) & pending & ~int_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      missed    <= '0;
      mask      <= '1;
      int_ack_d <= '0;
      dev_ack   <= '0;
      reg_rdata <= '0;
    end else begin
      // Set is OR-ed in after the clear so a collision keeps the request.
      pending   <= (pending & ~int_ack) | set_ev;
      // Same ordering for missed: a fresh miss beats a W1C in that cycle.
      missed    <= (missed & ~missed_w1c) | miss_ev;
      int_ack_d <= int_ack;
      dev_ack   <= int_ack & ~int_ack_d;

      if (reg_wr && reg_addr == IRQ_REG_MASK) begin
        mask <= reg_wdata;
      end

      // Reads sample pre-edge state, so a same-cycle write returns the old value.
      if (reg_rd) begin
        case (irq_reg_e'(reg_addr))
          IRQ_REG_MASK:    reg_rdata <= mask;
          IRQ_REG_PENDING: reg_rdata <= pending;
          IRQ_REG_MISSED:  reg_rdata <= missed;
          default:         reg_rdata <= '0;
        endcase
      end
    end
  end

  assign int_vec = pending & ~mask;

endmodule

// File: tb/tb_mbssoc_irq_collector.sv
// ---------------------------------------------------------------------------
// tb_mbssoc_irq_collector
//   Directed self-checking bench for mbssoc_irq_collector. Source 7 is
//   configured level-triggered; all others are edge-triggered.
// ---------------------------------------------------------------------------
module tb_mbssoc_irq_collector;
  import mbssoc_irq_collector_pkg::*;

  localparam int W = INT_SEL_WIDTH;
  localparam int LVL = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] irq_in;
  logic [W-1:0] int_ack;
  logic [W-1:0] int_vec;
  logic [W-1:0] dev_ack;
  logic         reg_wr;
  logic         reg_rd;
  logic [1:0]   reg_addr;
  logic [W-1:0] reg_wdata;
  logic [W-1:0] reg_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mbssoc_irq_collector #(
    .W           (W),
    .EDGE_MASK   (8'h7F),
    .SOFT_MASK   (8'h03),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .int_ack   (int_ack),
    .int_vec   (int_vec),
    .dev_ack   (dev_ack),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [W-1:0] data);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    tick();
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [W-1:0] data);
    reg_rd = 1'b1; reg_addr = addr;
    tick();
    reg_rd = 1'b0;
    data = reg_rdata;
  endtask

  task automatic pulse(input int idx);
    irq_in[idx] = 1'b1;
    tick();
    irq_in[idx] = 1'b0;
  endtask

  task automatic ack(input logic [W-1:0] bits);
    int_ack = bits;
    tick();
    int_ack = '0;
  endtask

  initial begin
    logic [W-1:0] rd;
    int           pulses;

    rst = 1'b1; irq_in = '0; int_ack = '0;
    reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset int_vec", int_vec, 8'h00);
    check("reset dev_ack", dev_ack, 8'h00);
    check("reset rdata", reg_rdata, 8'h00);
    reg_read(IRQ_REG_MASK, rd);
    check("reset mask", rd, 8'hFF);

    // 1: reset mid-operation, also checks the 3-cycle latency
    reg_write(IRQ_REG_MASK, 8'h00);
    irq_in = 8'h14;
    tick(); tick();
    check("t1 latency-2", int_vec, 8'h00);
    tick();
    check("t1 latency-3", int_vec, 8'h14);
    reg_read(IRQ_REG_PENDING, rd);
    check("t1 pending", rd, 8'h14);
    irq_in = '0;
    rst = 1'b1;
    #1;
    check("t1 async int_vec", int_vec, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    reg_read(IRQ_REG_MASK, rd);
    check("t1 mask", rd, 8'hFF);
    reg_read(IRQ_REG_MISSED, rd);
    check("t1 missed", rd, 8'h00);
    reg_read(IRQ_REG_PENDING, rd);
    check("t1 pending clr", rd, 8'h00);

    // 2: edge path with held ack
    reg_write(IRQ_REG_MASK, 8'h00);
    pulse(INT_UART);
    check("t2 vec c1", int_vec, 8'h00);
    tick();
    check("t2 vec c2", int_vec, 8'h00);
    tick();
    check("t2 vec c3", int_vec, 8'h10);
    int_ack[INT_UART] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) check("t2 dev_ack first", dev_ack, 8'h10);
      if (dev_ack[INT_UART]) pulses++;
    end
    int_ack = '0;
    tick();
    if (dev_ack[INT_UART]) pulses++;
    check("t2 dev_ack pulses", 8'(pulses), 8'd1);
    check("t2 vec cleared", int_vec, 8'h00);

    // 3: set/clear collision
    pulse(INT_UART);
    tick(); tick();
    check("t3 pend", int_vec, 8'h10);
    pulse(INT_UART);
    tick();
    int_ack[INT_UART] = 1'b1;
    tick();
    check("t3 collision", int_vec, 8'h10);
    tick();
    check("t3 cleared", int_vec, 8'h00);
    int_ack = '0;
    tick();
    reg_read(IRQ_REG_MISSED, rd);
    check("t3 no miss", rd, 8'h00);

    // 4: missed flag on keyboard
    pulse(INT_KEYBOARD);
    tick(); tick();
    pulse(INT_KEYBOARD);
    tick(); tick();
    reg_read(IRQ_REG_MISSED, rd);
    check("t4 missed", rd, 8'h04);
    reg_write(IRQ_REG_MISSED, 8'h04);
    reg_read(IRQ_REG_MISSED, rd);
    check("t4 w1c", rd, 8'h00);
    pulse(INT_KEYBOARD);
    tick();
    reg_write(IRQ_REG_MISSED, 8'h04);
    reg_read(IRQ_REG_MISSED, rd);
    check("t4 miss beats w1c", rd, 8'h04);
    reg_write(IRQ_REG_MISSED, 8'h04);
    ack(8'h04);
    tick();
    check("t4 vec clr", int_vec, 8'h00);

    // 5: masking
    reg_write(IRQ_REG_MASK, 8'hFF);
    pulse(INT_STORAGE);
    tick(); tick();
    check("t5 masked vec", int_vec, 8'h00);
    reg_read(IRQ_REG_PENDING, rd);
    check("t5 pending raw", rd, 8'h20);
    reg_write(IRQ_REG_MASK, 8'h00);
    check("t5 unmask", int_vec, 8'h20);
    ack(8'h20);
    tick();

    // 6: software set and level source
    reg_write(IRQ_REG_SWSET, 8'hFF);
    check("t6 swset vec", int_vec, 8'h03);
    reg_read(IRQ_REG_PENDING, rd);
    check("t6 swset pend", rd, 8'h03);
    reg_read(IRQ_REG_SWSET, rd);
    check("t6 swset rd0", rd, 8'h00);
    ack(8'h03);
    tick();
    check("t6 sw clr", int_vec, 8'h00);
    irq_in[LVL] = 1'b1;
    tick(); tick(); tick();
    check("t6 level pend", int_vec, 8'h80);
    ack(8'h80);
    check("t6 level re-pend", int_vec, 8'h80);
    tick();
    check("t6 level hold", int_vec, 8'h80);
    reg_write(IRQ_REG_MASK, 8'h80);
    check("t6 level masked", int_vec, 8'h00);
    reg_read(IRQ_REG_PENDING, rd);
    check("t6 level pend rd", rd, 8'h80);
    reg_read(IRQ_REG_MISSED, rd);
    check("t6 level no miss", rd, 8'h00);
    // Simultaneous read and write of MASK returns the old value.
    reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = IRQ_REG_MASK; reg_wdata = 8'h00;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    check("t6 rw old", reg_rdata, 8'h80);
    check("t6 rw new vec", int_vec, 8'h80);
    irq_in[LVL] = 1'b0;
    tick(); tick(); tick();
    ack(8'h80);
    tick();
    reg_read(IRQ_REG_PENDING, rd);
    check("t6 final pend", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
